instr_fetch_seq: RTL
====================

Name: instr_fetch_seq

Overview:
Upstream instruction sequencer for the 8-bit Processor core.
- Holds a small program memory. Each entry is an 8-bit instruction plus its 8-bit operand.
- Steps a program counter through the memory and drives the Processor's `instruction` and `dataIn` inputs, one entry per issue slot.
- Replaces hand-driven stimulus: the bench or a host loads a program, pulses `start`, and the block sequences LOAD/STORE/ADD/SUB words until a HALT opcode or the end of memory.

Parameters:
- DEPTH, 16, number of program entries.
- AW, 4, program address width; DEPTH = 2**AW.
- HALT_OP, 4'hF, opcode in instruction[7:4] that terminates the program. The HALT entry is never issued.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- prog_we  input  1  program-memory write strobe.
- prog_addr  input  AW  program-memory write address.
- prog_instr  input  8  instruction byte to write.
- prog_data  input  8  operand byte to write.
- start  input  1  begin execution from address 0.
- stall  input  1  downstream not ready; freezes the issue slot.
- instruction  output  8  instruction to Processor.
- dataIn  output  8  operand to Processor.
- pc  output  AW  address of the entry currently fetched or issued.
- issue_valid  output  1  instruction/dataIn are a new, valid issue this cycle.
- busy  output  1  high in FETCH or ISSUE.
- done  output  1  high in HALT.

Behaviour:
- Reset (rst=1 at clock edge):
  - State goes to IDLE; pc=0.
  - instruction=8'h00, dataIn=8'h00, issue_valid=0, busy=0, done=0.
  - Program memory contents are not cleared.
- Program memory:
  - DEPTH x 16-bit array, single write port.
  - Write occurs when prog_we=1 and state is IDLE or HALT. prog_we is ignored while busy.
  - Read is synchronous: the address is registered in FETCH and the data is available in ISSUE.
- State machine: IDLE, FETCH, ISSUE, HALT.
  - IDLE:
    - If start=1 and prog_we=0: pc<=0, go to FETCH.
    - If start=1 and prog_we=1 in the same cycle: the write wins and start is ignored.
  - FETCH: read mem[pc]; go to ISSUE next cycle. busy=1.
  - ISSUE, fetched opcode == HALT_OP: go to HALT. No issue; instruction/dataIn keep their previous values.
  - ISSUE, stall=1: issue_valid=0; instruction/dataIn hold; remain in ISSUE; pc holds.
  - ISSUE, stall=0:
    - Drive instruction=mem[pc][15:8] and dataIn=mem[pc][7:0]; issue_valid=1 for exactly this one cycle.
    - If pc==DEPTH-1: go to HALT, pc holds. No wrap-around.
    - Otherwise: pc<=pc+1, go to FETCH.
  - HALT: done=1, busy=0. start=1 (with prog_we=0) sets pc<=0 and goes to FETCH (restart).
- Latency and throughput:
  - start sampled at edge N gives issue_valid=1 in the cycle after edge N+2.
  - Steady state: one issue every 2 cycles.
  - Each stall cycle adds exactly one cycle.
- Output hold: outside issue cycles, instruction/dataIn retain the last issued values (or 0 after reset). The consumer qualifies them with issue_valid.
- start while busy is ignored.
- Reset mid-program: synchronous return to IDLE with all outputs at reset values. The next start runs from address 0 with the memory intact.
- pc arithmetic is AW-bit unsigned. pc never exceeds DEPTH-1.

Test Plan:
- Load 0:{00,10} 1:{10,20} 2:{20,05} 3:{30,03} 4:{F0,00}, then pulse start. Required response:
  - Issues (00,10), (10,20), (20,05), (30,03) on 4 issue_valid pulses spaced 2 cycles apart.
  - First pulse 2 cycles after start.
  - done=1 after the 4th issue; HALT entry never issued.
- Same program, with stall=1 held for 3 cycles during the 2nd issue:
  - issue_valid stays 0 while stalled; outputs hold (00,10); pc stays 1.
  - (10,20) issues on the first cycle stall=0.
  - Total run is 3 cycles longer.
- Fill all 16 entries with opcode 2 and operands 0x00..0x0F, no HALT:
  - 16 issues, last is (20,0F).
  - done=1 with pc=15; no wrap to entry 0.
- Assert rst for one cycle during the 3rd issue:
  - Next cycle: IDLE, instruction=00, dataIn=00, busy=0, pc=0.
  - Re-start reissues from entry 0 with the same contents.
- While busy, pulse prog_we at addr 2 with {30,FF}: no effect on execution. After HALT, write it again and restart: entry 2 issues (30,FF).
- In IDLE, assert start and prog_we together: the write occurs, state stays IDLE, no issue_valid.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Host/processor-side bus of the instruction fetch sequencer: program load,
// run control, and the issue stream toward the Processor core.
interface instr_fetch_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_instr;
  logic [7:0]    prog_data;
  logic          start;
  logic          stall;
  logic [7:0]    instruction;
  logic [7:0]    dataIn;
  logic [AW-1:0] pc;
  logic          issue_valid;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_instr, prog_data, start, stall,
    input  instruction, dataIn, pc, issue_valid, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_instr, prog_data, start, stall,
    output instruction, dataIn, pc, issue_valid, busy, done
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction sequencer: walks a small program memory and issues one
// instruction/operand pair to the Processor per FETCH/ISSUE round trip.
module instr_fetch_seq #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input logic         clk,
  input logic         rst,
  instr_fetch_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  logic [15:0]   mem [DEPTH];
  logic [1:0]    state;
  logic [AW-1:0] pc_r;
  logic [15:0]   rdata_p0;
  logic [7:0]    instr_p1;
  logic [7:0]    data_p1;
  logic          vld_p1;
  logic          can_load;

  // Program loading is only allowed while nothing is being sequenced.
  assign can_load = (state == ST_IDLE) || (state == ST_HALT);

  // Stage 0: program memory write port and registered read of mem[pc]
  always_ff @(posedge clk) begin
    if (bus.prog_we && can_load) begin
      mem[bus.prog_addr] <= {bus.prog_instr, bus.prog_data};
    end
    if (state == ST_FETCH) begin
      rdata_p0 <= mem[pc_r];
    end
  end

  // Stage 1: sequencing and issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc_r     <= '0;
      vld_p1   <= 1'b0;
      instr_p1 <= 8'h00;
      data_p1  <= 8'h00;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          // A same-cycle program write takes priority over start.
          if (bus.start && !bus.prog_we) begin
            pc_r  <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_ISSUE;
        ST_ISSUE: begin
          if (rdata_p0[15:12] == HALT_OP) begin
            state <= ST_HALT;
          end else if (!bus.stall) begin
            vld_p1   <= 1'b1;
            instr_p1 <= rdata_p0[15:8];
            data_p1  <= rdata_p0[7:0];
            if (pc_r == LAST_PC) begin
              state <= ST_HALT;
            end else begin
              pc_r  <= pc_r + AW'(1);
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instruction = instr_p1;
  assign bus.dataIn      = data_p1;
  assign bus.pc          = pc_r;
  assign bus.issue_valid = vld_p1;
  assign bus.busy        = (state == ST_FETCH) || (state == ST_ISSUE);
  assign bus.done        = (state == ST_HALT);

endmodule
